alu_exec_unit: RTL and testbench

Handshaked execution unit that consumes the decoded ALU operation (`operation_t`) and error flag from the ALU control decoder and produces the result. It sits in the execute stage between the decoder and the writeback register. ADD, SUB, SLT, SLTU, XOR, OR, AND and FWD complete in one cycle. SLL, SRL and SRA run on an iterative one-bit-per-cycle shifter to save area.

---
 rtl/alu_exec_pkg.sv | 24 ++
 rtl/alu_exec_unit.sv | 157 +++++++++++++++
 tb/tb_alu_exec_unit.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_pkg.sv
// Shared types between the ALU control decoder and the execute-stage ALU.
package alu_exec_pkg;

  // Encodings 11..15 are undefined and are reported as errored requests.
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SLL  = 4'd2,
    OP_SLT  = 4'd3,
    OP_SLTU = 4'd4,
    OP_XOR  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_OR   = 4'd8,
    OP_AND  = 4'd9,
    OP_FWD  = 4'd10
  } operation_t;

  typedef enum logic {
    LOW  = 1'b0,
    HIGH = 1'b1
  } flag_t;

endpackage

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: 1-cycle latency for most ops, shamt+1 for shifts (one bit per cycle).
// Result held under out_ready backpressure; in_ready falls through from out_ready while DONE.
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             in_valid,
  output logic             in_ready,
  input  operation_t       opSel,
  input  flag_t            err_in,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output flag_t            err_out
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SHW-1:0]   r_count;
  logic [WIDTH-1:0] r_shreg;
  operation_t       r_op;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  flag_t            r_err;

  logic             w_accept;
  logic             w_legal;
  logic             w_is_shift;
  logic             w_ld_res;
  logic             w_ld_shift;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_alu;
  logic [WIDTH-1:0] w_shift_step;
  logic [WIDTH-1:0] w_res_nxt;
  flag_t            w_err_nxt;

  assign w_shamt   = srcB[SHW-1:0];
  assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign zero      = r_zero;
  assign err_out   = r_err;

  always_comb begin
    w_alu      = '0;
    w_legal    = 1'b1;
    w_is_shift = 1'b0;
    case (opSel)
      OP_ADD:  w_alu = srcA + srcB;
      OP_SUB:  w_alu = srcA - srcB;
      OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
      OP_SLTU: w_alu = {{(WIDTH-1){1'b0}}, (srcA < srcB)};
      OP_XOR:  w_alu = srcA ^ srcB;
      OP_OR:   w_alu = srcA | srcB;
      OP_AND:  w_alu = srcA & srcB;
      OP_FWD:  w_alu = srcA;
      OP_SLL, OP_SRL, OP_SRA: begin
        // Only reaches the result directly when shamt is zero.
        w_is_shift = 1'b1;
        w_alu      = srcA;
      end
      default: w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_shift_step = {1'b0, r_shreg[WIDTH-1:1]};
    case (r_op)
      OP_SLL:  w_shift_step = {r_shreg[WIDTH-2:0], 1'b0};
      OP_SRA:  w_shift_step = {r_shreg[WIDTH-1], r_shreg[WIDTH-1:1]};
      default: w_shift_step = {1'b0, r_shreg[WIDTH-1:1]};
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ld_res    = 1'b0;
    w_ld_shift  = 1'b0;
    w_res_nxt   = '0;
    w_err_nxt   = LOW;
    // An accept is only possible from IDLE or a draining DONE, so both share this path.
    if (w_accept) begin
      if ((err_in == HIGH) || !w_legal) begin
        w_ld_res    = 1'b1;
        w_err_nxt   = HIGH;
        w_state_nxt = DONE;
      end else if (w_is_shift && (w_shamt != '0)) begin
        w_ld_shift  = 1'b1;
        w_state_nxt = SHIFT;
      end else begin
        w_ld_res    = 1'b1;
        w_res_nxt   = w_alu;
        w_state_nxt = DONE;
      end
    end else begin
      case (r_state)
        SHIFT: begin
          if (r_count == SHW'(1)) begin
            w_ld_res    = 1'b1;
            w_res_nxt   = w_shift_step;
            w_state_nxt = DONE;
          end
        end
        DONE: begin
          if (out_ready) w_state_nxt = IDLE;
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_count  <= '0;
      r_shreg  <= '0;
      r_op     <= OP_ADD;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_err    <= LOW;
    end else begin
      if (w_ld_shift) begin
        r_shreg <= srcA;
        r_count <= w_shamt;
        r_op    <= opSel;
      end else if (r_state == SHIFT) begin
        r_shreg <= w_shift_step;
        r_count <= r_count - SHW'(1);
      end
      if (w_ld_res) begin
        r_result <= w_res_nxt;
        r_zero   <= (w_res_nxt == '0);
        r_err    <= w_err_nxt;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboarded bench for alu_exec_unit: directed cases then randomized traffic with random backpressure.
module tb_alu_exec_unit;
  import alu_exec_pkg::*;

  localparam int W = 32;

  logic         clk       = 1'b0;
  logic         rstN      = 1'b1;
  logic         in_valid  = 1'b0;
  logic         in_ready;
  operation_t   opSel     = OP_ADD;
  flag_t        err_in    = LOW;
  logic [W-1:0] srcA      = '0;
  logic [W-1:0] srcB      = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero;
  flag_t        err_out;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk(clk), .rstN(rstN),
    .in_valid(in_valid), .in_ready(in_ready),
    .opSel(opSel), .err_in(err_in), .srcA(srcA), .srcB(srcB),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .err_out(err_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic         zero;
    logic         err;
    int           lat;
    int           acc;
  } exp_t;

  exp_t  sbq[$];
  string nmq[$];
  int    checks = 0, errors = 0, cyc = 0, last_acc = 0, rdy_mode = 0;
  logic  rdy_force = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: direct arithmetic on the operands; shifts expressed as whole-word shifts.
  function automatic exp_t model(operation_t op, flag_t e, logic [W-1:0] a, logic [W-1:0] b);
    exp_t x;
    int   sh;
    logic ok;
    sh    = int'(b % W);
    ok    = 1'b1;
    x.res = '0;
    x.err = 1'b0;
    x.lat = 1;
    x.acc = 0;
    case (op)
      OP_ADD:  x.res = a + b;
      OP_SUB:  x.res = a - b;
      OP_SLT:  x.res = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: x.res = {{(W-1){1'b0}}, (a < b)};
      OP_XOR:  x.res = a ^ b;
      OP_OR:   x.res = a | b;
      OP_AND:  x.res = a & b;
      OP_FWD:  x.res = a;
      OP_SLL:  begin x.res = a << sh;           x.lat = sh + 1; end
      OP_SRL:  begin x.res = a >> sh;           x.lat = sh + 1; end
      OP_SRA:  begin x.res = $signed(a) >>> sh; x.lat = sh + 1; end
      default: ok = 1'b0;
    endcase
    if (e == HIGH || !ok) begin
      x.res = '0;
      x.err = 1'b1;
      x.lat = 1;
    end
    x.zero = (x.res == '0);
    return x;
  endfunction

  task automatic issue(string nm, operation_t op, flag_t e, logic [W-1:0] a, logic [W-1:0] b);
    exp_t x;
    int   guard;
    x     = model(op, e, a, b);
    guard = 0;
    @(negedge clk);
    opSel = op; err_in = e; srcA = a; srcB = b; in_valid = 1'b1;
    forever begin
      #4;
      if (in_ready) begin
        x.acc    = cyc;
        last_acc = cyc;
        sbq.push_back(x);
        nmq.push_back(nm);
        @(posedge clk);
        break;
      end
      guard++;
      if (guard > 200) begin
        chk({nm, "_accept_timeout"}, 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Idle cycles scramble the request inputs to show they are ignored without in_valid.
  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      opSel    = operation_t'(4'($urandom_range(0, 15)));
      err_in   = flag_t'(1'($urandom_range(0, 1)));
      srcA     = $urandom;
      srcB     = $urandom;
    end
  endtask

  initial forever begin
    @(negedge clk);
    #1;
    out_ready = (rdy_mode != 0) ? ($urandom_range(0, 3) != 0) : rdy_force;
  end

  // Monitor: samples just before each rising edge and retires the scoreboard head on handshake.
  initial begin
    logic           seen;
    logic [W+1:0]   held;
    string          nm;
    exp_t           x;
    seen = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      #4;
      if (!rstN) begin
        seen = 1'b0;
        continue;
      end
      if (out_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_out_valid", 64'(out_valid), 64'd0);
        end else begin
          x  = sbq[0];
          nm = nmq[0];
          if (!seen) begin
            chk({nm, "_latency"}, 64'(cyc - x.acc), 64'(x.lat));
            seen = 1'b1;
            held = {result, zero, err_out};
          end else begin
            chk({nm, "_hold"}, 64'({result, zero, err_out}), 64'(held));
          end
          if (out_ready) begin
            chk({nm, "_result"}, 64'(result), 64'(x.res));
            chk({nm, "_zero"}, 64'(zero), 64'(x.zero));
            chk({nm, "_err"}, 64'(err_out), 64'(x.err));
            void'(sbq.pop_front());
            void'(nmq.pop_front());
            seen = 1'b0;
          end else begin
            chk({nm, "_in_ready_stall"}, 64'(in_ready), 64'd0);
          end
        end
      end
    end
  end

  initial begin
    int a0;
    int g;
    operation_t op;
    flag_t      e;
    logic [W-1:0] ra, rb;

    #1 rstN = 1'b0;
    idle(3);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_result", 64'(result), 64'd0);
    chk("reset_zero", 64'(zero), 64'd0);
    chk("reset_err", 64'(err_out), 64'd0);
    @(negedge clk);
    rstN = 1'b1;
    #1 chk("in_ready_after_reset", 64'(in_ready), 64'd1);

    rdy_force = 1'b1;
    issue("add_wrap", OP_ADD, LOW, 32'hFFFF_FFFF, 32'd1);
    a0 = last_acc;
    issue("sub_wrap", OP_SUB, LOW, 32'd0, 32'd1);
    chk("b2b_accept_gap", 64'(last_acc - a0), 64'd1);
    issue("slt_neg", OP_SLT, LOW, 32'h8000_0000, 32'd1);
    issue("sltu_big", OP_SLTU, LOW, 32'h8000_0000, 32'd1);
    issue("sltu_eq", OP_SLTU, LOW, 32'd5, 32'd5);
    idle(2);

    issue("sra4", OP_SRA, LOW, 32'hF000_0000, 32'd4);
    issue("srl4", OP_SRL, LOW, 32'hF000_0000, 32'd4);
    issue("sll31", OP_SLL, LOW, 32'd1, 32'd31);
    issue("sll0", OP_SLL, LOW, 32'hDEAD_BEEF, 32'h0000_0020);
    issue("fwd", OP_FWD, LOW, 32'h0000_1234, 32'h0000_FFFF);
    issue("err_sub", OP_SUB, HIGH, 32'd7, 32'd3);
    issue("after_err", OP_ADD, LOW, 32'd3, 32'd4);
    issue("illegal_op", operation_t'(4'd13), LOW, 32'd5, 32'd9);
    issue("err_shift", OP_SLL, HIGH, 32'd1, 32'd9);
    idle(40);

    rdy_force = 1'b0;
    issue("xor_bp", OP_XOR, LOW, 32'h0000_00A5, 32'h0000_000F);
    idle(12);
    rdy_force = 1'b1;
    idle(3);

    issue("sra20_reset", OP_SRA, LOW, 32'h8000_0000, 32'd20);
    idle(3);
    #2;
    rstN = 1'b0;
    sbq.delete();
    nmq.delete();
    #1;
    chk("midshift_reset_out_valid", 64'(out_valid), 64'd0);
    chk("midshift_reset_result", 64'(result), 64'd0);
    chk("midshift_reset_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rstN = 1'b1;
    idle(30);
    chk("no_stale_after_reset", 64'(out_valid), 64'd0);

    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) < 18) op = operation_t'(4'($urandom_range(0, 10)));
      else                            op = operation_t'(4'($urandom_range(11, 15)));
      e  = ($urandom_range(0, 19) == 0) ? HIGH : LOW;
      ra = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 1) == 1) rb = W'($urandom_range(0, 9));
      if ($urandom_range(0, 9) == 0) rb = ra;
      issue($sformatf("rnd%0d", i), op, e, ra, rb);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    rdy_mode  = 0;
    rdy_force = 1'b1;
    g = 0;
    while (sbq.size() != 0 && g < 500) begin
      idle(1);
      g++;
    end
    chk("drain_pending", 64'(sbq.size()), 64'd0);
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
